// File: rtl/alu_pkg.sv
// Shared definitions for the ALU and its downstream result FIFO.
//   ALU_W      : ALU datapath width
//   alu_op_t   : 3-bit op code type, plus the op encoding constants
//   alu_res_t  : one FIFO entry {op, carry, zero, result}
package alu_pkg;

  localparam int ALU_W = 32;

  typedef logic [2:0] alu_op_t;

  localparam alu_op_t OP_ADD  = 3'b000;
  localparam alu_op_t OP_SUB  = 3'b001;
  localparam alu_op_t OP_AND  = 3'b010;
  localparam alu_op_t OP_OR   = 3'b011;
  localparam alu_op_t OP_XOR  = 3'b100;
  localparam alu_op_t OP_NAND = 3'b101;
  localparam alu_op_t OP_SHL  = 3'b110;
  localparam alu_op_t OP_SHR  = 3'b111;

  typedef struct packed {
    alu_op_t            op;
    logic               carry;
    logic               zero;
    logic [ALU_W-1:0]   result;
  } alu_res_t;

endpackage

// File: rtl/alu_res_mem.sv
// Entry storage for the ALU result FIFO: DEPTH x WIDTH register array,
// one synchronous write port, one asynchronous (show-ahead) read port.
// Contents are deliberately not reset.
//   clk      : rising-edge clock
//   wr_en    : write strobe
//   wr_addr  : write slot
//   wr_data  : entry to store
//   rd_addr  : read slot
//   rd_data  : entry at rd_addr, combinational
module alu_res_mem #(
  parameter int WIDTH = 35,
  parameter int DEPTH = 4,
  localparam int PTR_W = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             wr_en,
  input  logic [PTR_W-1:0] wr_addr,
  input  logic [WIDTH-1:0] wr_data,
  input  logic [PTR_W-1:0] rd_addr,
  output logic [WIDTH-1:0] rd_data
);

  logic [WIDTH-1:0] mem [DEPTH];

  // One enable-decoded register per slot.
  generate
    for (genvar gi = 0; gi < DEPTH; gi++) begin : g_slot
      always_ff @(posedge clk) begin
        if (wr_en && (wr_addr == PTR_W'(gi))) begin
          mem[gi] <= wr_data;
        end
      end
    end
  endgenerate

  assign rd_data = mem[rd_addr];

endmodule

// File: rtl/alu_result_fifo.sv
// Show-ahead FIFO capturing ALU results with their zero/carry flags and op
// code, with valid/ready on both sides and saturating flag statistics.
//   clk, rst_n                 : clock, asynchronous active-low reset
//   in_valid/in_ready          : producer handshake (in_ready = !full)
//   in_result/zero/carry/op    : entry presented by the ALU
//   out_valid/out_ready        : consumer handshake (out_valid = !empty)
//   out_result/zero/carry/op   : head entry, forced to 0 while empty
//   level                      : occupied entries
//   clr_stats                  : synchronous clear of both counters
//   zero_cnt/carry_cnt         : saturating counts of accepted flags
module alu_result_fifo
  import alu_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int DEPTH  = 4,
  parameter int CNT_W  = 16
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [DATA_W-1:0]        in_result,
  input  logic                     in_zero,
  input  logic                     in_carry,
  input  alu_op_t                  in_op,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [DATA_W-1:0]        out_result,
  output logic                     out_zero,
  output logic                     out_carry,
  output alu_op_t                  out_op,
  output logic [$clog2(DEPTH):0]   level,
  input  logic                     clr_stats,
  output logic [CNT_W-1:0]         zero_cnt,
  output logic [CNT_W-1:0]         carry_cnt
);

  localparam int PTR_W   = $clog2(DEPTH);
  localparam int LVL_W   = PTR_W + 1;
  localparam int ENTRY_W = DATA_W + 5;

  logic [PTR_W-1:0]   wr_ptr_reg, rd_ptr_reg;
  logic [LVL_W-1:0]   level_reg, level_next;
  logic [CNT_W-1:0]   zero_cnt_reg, carry_cnt_reg;
  logic               full, empty, wr_en, rd_en;
  logic [ENTRY_W-1:0] wr_data, rd_data;

  // Occupancy alone decides full/empty, so pointers may wrap freely.
  assign full  = (level_reg == LVL_W'(DEPTH));
  assign empty = (level_reg == '0);
  assign wr_en = in_valid && !full;
  assign rd_en = out_ready && !empty;

  assign wr_data = {in_op, in_carry, in_zero, in_result};

  alu_res_mem #(
    .WIDTH (ENTRY_W),
    .DEPTH (DEPTH)
  ) u_mem (
    .clk     (clk),
    .wr_en   (wr_en),
    .wr_addr (wr_ptr_reg),
    .wr_data (wr_data),
    .rd_addr (rd_ptr_reg),
    .rd_data (rd_data)
  );

  always_comb begin
    level_next = level_reg;
    case ({wr_en, rd_en})
      2'b10:   level_next = level_reg + 1'b1;
      2'b01:   level_next = level_reg - 1'b1;
      default: level_next = level_reg;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      level_reg  <= '0;
    end else begin
      if (wr_en) wr_ptr_reg <= wr_ptr_reg + 1'b1;
      if (rd_en) rd_ptr_reg <= rd_ptr_reg + 1'b1;
      level_reg <= level_next;
    end
  end

  // Clear wins over a same-cycle increment; counters stick at all-ones.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      zero_cnt_reg  <= '0;
      carry_cnt_reg <= '0;
    end else if (clr_stats) begin
      zero_cnt_reg  <= '0;
      carry_cnt_reg <= '0;
    end else if (wr_en) begin
      if (in_zero && (zero_cnt_reg != {CNT_W{1'b1}}))
        zero_cnt_reg <= zero_cnt_reg + 1'b1;
      if (in_carry && (carry_cnt_reg != {CNT_W{1'b1}}))
        carry_cnt_reg <= carry_cnt_reg + 1'b1;
    end
  end

  assign in_ready   = !full;
  assign out_valid  = !empty;
  // Storage is never reset, so mask the head while nothing is held.
  assign out_result = empty ? '0 : rd_data[DATA_W-1:0];
  assign out_zero   = empty ? 1'b0 : rd_data[DATA_W];
  assign out_carry  = empty ? 1'b0 : rd_data[DATA_W+1];
  assign out_op     = empty ? '0 : alu_op_t'(rd_data[DATA_W+4:DATA_W+2]);
  assign level      = level_reg;
  assign zero_cnt   = zero_cnt_reg;
  assign carry_cnt  = carry_cnt_reg;

endmodule

// File: tb/tb_alu_result_fifo.sv
module tb_alu_result_fifo;
  import alu_pkg::*;

  localparam int DEPTH  = 4;
  localparam int CNT_W  = 4;
  localparam int DATA_W = 32;
  localparam int LW     = $clog2(DEPTH) + 1;
  localparam int SAT    = (1 << CNT_W) - 1;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              in_valid, in_ready, in_zero, in_carry;
  logic [DATA_W-1:0] in_result;
  alu_op_t           in_op;
  logic              out_valid, out_ready, out_zero, out_carry;
  logic [DATA_W-1:0] out_result;
  alu_op_t           out_op;
  logic [LW-1:0]     level;
  logic              clr_stats;
  logic [CNT_W-1:0]  zero_cnt, carry_cnt;

  int total = 0;
  int bad   = 0;
  bit checking = 0;

  always #5 clk = ~clk;

  alu_result_fifo #(.DATA_W(DATA_W), .DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready), .in_result(in_result),
    .in_zero(in_zero), .in_carry(in_carry), .in_op(in_op),
    .out_valid(out_valid), .out_ready(out_ready), .out_result(out_result),
    .out_zero(out_zero), .out_carry(out_carry), .out_op(out_op),
    .level(level), .clr_stats(clr_stats),
    .zero_cnt(zero_cnt), .carry_cnt(carry_cnt)
  );

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: a queue of entries plus two plain integer counters.
  alu_res_t q[$];
  int zc = 0, cc = 0;

  always @(negedge rst_n) begin
    q.delete();
    zc = 0;
    cc = 0;
  end

  always @(posedge clk) begin
    bit wr, rd;
    if (rst_n === 1'b1) begin
      wr = in_valid && (q.size() < DEPTH);
      rd = out_ready && (q.size() > 0);
      if (rd) void'(q.pop_front());
      if (wr) q.push_back('{op: in_op, carry: in_carry, zero: in_zero, result: in_result});
      if (clr_stats) begin
        zc = 0;
        cc = 0;
      end else if (wr) begin
        if (in_zero && zc < SAT) zc++;
        if (in_carry && cc < SAT) cc++;
      end
    end
  end

  // Per-cycle comparison of every output against the model.
  always @(negedge clk) begin
    alu_res_t head;
    if (checking) begin
      head = (q.size() > 0) ? q[0] : '0;
      chk("cycle",
          {14'd0, in_ready, out_valid, level, out_op, out_carry, out_zero, out_result, zero_cnt, carry_cnt},
          {14'd0, q.size() < DEPTH, q.size() > 0, LW'(q.size()), head, CNT_W'(zc), CNT_W'(cc)});
    end
  end

  task automatic push(input logic [DATA_W-1:0] d, input logic z, input logic c, input alu_op_t op);
    bit acc;
    int n;
    n = 0;
    in_valid = 1'b1; in_result = d; in_zero = z; in_carry = c; in_op = op;
    do begin
      @(negedge clk);
      acc = in_ready;
      @(posedge clk); #1;
      n++;
    end while (!acc && n < 50);
    if (!acc) begin
      total++;
      bad++;
      $display("FAIL push_timeout: got in_ready=0 expected accept of %0h", d);
    end
    in_valid = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0;
    in_valid = 0; in_result = '0; in_zero = 0; in_carry = 0; in_op = OP_ADD;
    out_ready = 0; clr_stats = 0;
    repeat (3) @(posedge clk);
    checking = 1;
    #1 rst_n = 1'b1;

    // Reset state
    @(negedge clk);
    chk("rst_in_ready", in_ready, 1);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_level", level, 0);
    chk("rst_cnts", {zero_cnt, carry_cnt}, 0);
    chk("rst_out_result", out_result, 0);

    // Fill with consumer stalled, hold a 5th write, then drain
    @(posedge clk); #1;
    for (int i = 1; i <= 4; i++) push(i, 0, 0, OP_ADD);
    @(negedge clk);
    chk("full_level", level, 4);
    chk("full_in_ready", in_ready, 0);
    @(posedge clk); #1;
    in_valid = 1; in_result = 5;
    repeat (2) @(posedge clk);
    #1 in_valid = 0;
    @(negedge clk);
    chk("held_level", level, 4);
    @(posedge clk); #1 out_ready = 1;
    for (int i = 1; i <= 4; i++) begin
      @(negedge clk);
      chk("drain_order", out_result, i);
    end
    @(negedge clk);
    chk("drained_level", level, 0);
    @(posedge clk); #1 out_ready = 0;

    // Simultaneous read/write at level 2, pointers wrapping
    push(10, 0, 0, OP_OR);
    push(11, 0, 0, OP_OR);
    in_valid = 1; out_ready = 1;
    for (int k = 0; k < 6; k++) begin
      in_result = 12 + k;
      @(negedge clk);
      chk("rw_level", level, 2);
      @(posedge clk); #1;
    end
    in_valid = 0;
    @(negedge clk);
    chk("rw_head", out_result, 16);
    repeat (3) @(posedge clk);
    #1;

    // Flag statistics and clear priority
    push(0, 1, 1, OP_SUB);
    push(32'hFFFF_FFFE, 0, 1, OP_SHL);
    @(negedge clk);
    chk("flag_cnts", {zero_cnt, carry_cnt}, {4'd1, 4'd2});
    @(posedge clk); #1 clr_stats = 1;
    push(0, 1, 0, OP_XOR);
    clr_stats = 0;
    @(negedge clk);
    chk("clr_cnts", {zero_cnt, carry_cnt}, 0);

    // Saturation
    @(posedge clk); #1;
    for (int i = 0; i < 20; i++) push(i, 1, 0, OP_AND);
    @(negedge clk);
    chk("sat_zero", zero_cnt, 15);

    // Asynchronous reset with three entries pending
    @(posedge clk); #1;
    repeat (3) @(posedge clk);
    #1 out_ready = 0;
    for (int i = 0; i < 3; i++) push(32'h100 + i, 0, 0, OP_NAND);
    @(negedge clk);
    chk("pre_rst_level", level, 3);
    @(posedge clk); #3 rst_n = 0;
    #1;
    chk("async_out_valid", out_valid, 0);
    chk("async_level", level, 0);
    @(posedge clk); #1 rst_n = 1;
    push(32'hABCD, 0, 1, OP_SHR);
    @(negedge clk);
    chk("post_rst_head", {out_valid, out_result}, {1'b1, 32'hABCD});

    // Randomized traffic, producer holds its entry while stalled
    @(posedge clk); #1;
    for (int cyc = 0; cyc < 1500; cyc++) begin
      bit hold;
      @(negedge clk);
      hold = in_valid && !in_ready;
      @(posedge clk); #1;
      if (!hold) begin
        in_valid  = ($urandom_range(0, 3) != 0);
        in_result = $urandom;
        in_zero   = ($urandom_range(0, 2) == 0);
        in_carry  = $urandom_range(0, 1);
        in_op     = alu_op_t'($urandom_range(0, 7));
      end
      out_ready = ($urandom_range(0, 2) != 0);
      clr_stats = ($urandom_range(0, 40) == 0);
    end
    in_valid = 0; clr_stats = 0;
    @(negedge clk);
    checking = 0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
